// File: rtl/cond_type_decode_stage_pkg.sv
// Shared encodings for the condition/type decode stage and the condition checker.
package cond_type_decode_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_D = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b101;

  // One-hot bit positions of OutClass; they double as counter indices.
  localparam int         NUM_CLS = 5;
  localparam logic [2:0] CLS_R   = 3'd0;
  localparam logic [2:0] CLS_I   = 3'd1;
  localparam logic [2:0] CLS_D   = 3'd2;
  localparam logic [2:0] CLS_B   = 3'd3;
  localparam logic [2:0] CLS_U   = 3'd4;

  localparam int         NUM_CNT  = 6;
  localparam logic [2:0] SEL_R    = 3'd0;
  localparam logic [2:0] SEL_I    = 3'd1;
  localparam logic [2:0] SEL_D    = 3'd2;
  localparam logic [2:0] SEL_B    = 3'd3;
  localparam logic [2:0] SEL_U    = 3'd4;
  localparam logic [2:0] SEL_SKIP = 3'd5;

endpackage

// File: rtl/cond_type_decode_stage_cond_check.sv
// Combinational ARM condition-code evaluator against an NZCV flag nibble.
module cond_type_decode_stage_cond_check
  import cond_type_decode_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1; // AL and the 0xF encoding both execute
    endcase
  end

endmodule

// File: rtl/cond_type_decode_stage.sv
// Registered condition/type decode stage: NZCV register with bypass, one-hot class,
// one-entry valid/ready output register and saturating per-class statistics.
module cond_type_decode_stage
  import cond_type_decode_stage_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int TYPE_LSB = 25,
  parameter int TYPE_W   = 3,
  parameter int CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] InInstr,
  input  logic [1:0]         FlagWrite,
  input  logic [3:0]         FlagsIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [INSTR_W-1:0] OutInstr,
  output logic               OutCondMet,
  output logic [NUM_CLS-1:0] OutClass,
  output logic [3:0]         Flags,
  input  logic               CntClear,
  input  logic [2:0]         CntSel,
  output logic [CNT_W-1:0]   CntValue
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]  out_instr_q, out_instr_d;
  logic                out_cond_met_q, out_cond_met_d;
  logic [NUM_CLS-1:0]  out_class_q, out_class_d;
  logic [3:0]          flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CNT];
  logic [CNT_W-1:0]    cnt_d [NUM_CNT];

  logic [TYPE_W-1:0]   type_fld;
  logic                upper_zero;
  logic                accept;
  logic                cond_met;
  logic [2:0]          cls_idx;
  logic [2:0]          inc_idx;
  logic [NUM_CLS-1:0]  onehot;

  assign InReady  = ~out_valid_q | OutReady;
  assign accept   = InValid & InReady;
  assign type_fld = InInstr[TYPE_LSB +: TYPE_W];

  generate
    if (TYPE_W > 3) begin : g_wide_type
      assign upper_zero = ~|type_fld[TYPE_W-1:3];
    end else begin : g_narrow_type
      assign upper_zero = 1'b1;
    end
  endgenerate

  // Flag register next state is exactly the bypassed view the condition sees.
  always_comb begin
    flags_d = flags_q;
    if (FlagWrite[1]) flags_d[3:2] = FlagsIn[3:2];
    if (FlagWrite[0]) flags_d[1:0] = FlagsIn[1:0];
  end

  cond_type_decode_stage_cond_check u_cond_check (
    .cond (InInstr[INSTR_W-1 -: 4]),
    .nzcv (flags_d),
    .pass (cond_met)
  );

  always_comb begin
    cls_idx = CLS_U;
    if (upper_zero) begin
      case (type_fld[2:0])
        TYPE_R:  cls_idx = CLS_R;
        TYPE_I:  cls_idx = CLS_I;
        TYPE_D:  cls_idx = CLS_D;
        TYPE_B:  cls_idx = CLS_B;
        default: cls_idx = CLS_U;
      endcase
    end
    onehot          = '0;
    onehot[cls_idx] = 1'b1;
    inc_idx         = cond_met ? cls_idx : SEL_SKIP;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_cond_met_d = out_cond_met_q;
    out_class_d    = out_class_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_instr_d    = InInstr;
      out_cond_met_d = cond_met;
      out_class_d    = onehot & {NUM_CLS{cond_met}};
    end else if (OutReady) begin
      out_valid_d    = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (CntClear) begin
        cnt_d[i] = '0;
      end else if (accept && (3'(i) == inc_idx) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_cond_met_q <= 1'b0;
      out_class_q    <= '0;
      flags_q        <= '0;
      cnt_q          <= '{default: '0};
    end else begin
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_cond_met_q <= out_cond_met_d;
      out_class_q    <= out_class_d;
      flags_q        <= flags_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    case (CntSel)
      SEL_R:    CntValue = cnt_q[CLS_R];
      SEL_I:    CntValue = cnt_q[CLS_I];
      SEL_D:    CntValue = cnt_q[CLS_D];
      SEL_B:    CntValue = cnt_q[CLS_B];
      SEL_U:    CntValue = cnt_q[CLS_U];
      SEL_SKIP: CntValue = cnt_q[SEL_SKIP];
      default:  CntValue = '0;
    endcase
  end

  assign OutValid   = out_valid_q;
  assign OutInstr   = out_instr_q;
  assign OutCondMet = out_cond_met_q;
  assign OutClass   = out_class_q;
  assign Flags      = flags_q;

endmodule

// File: tb/tb_cond_type_decode_stage.sv
// Randomized and directed bench for cond_type_decode_stage against a behavioural model.
module tb_cond_type_decode_stage;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [31:0]   InInstr;
  logic [1:0]    FlagWrite;
  logic [3:0]    FlagsIn;
  logic          OutValid;
  logic          OutReady;
  logic [31:0]   OutInstr;
  logic          OutCondMet;
  logic [4:0]    OutClass;
  logic [3:0]    Flags;
  logic          CntClear;
  logic [2:0]    CntSel;
  logic [CW-1:0] CntValue;

  always #5 CLK = ~CLK;

  cond_type_decode_stage #(
    .INSTR_W (32),
    .TYPE_LSB(25),
    .TYPE_W  (3),
    .CNT_W   (CW)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .InInstr   (InInstr),
    .FlagWrite (FlagWrite),
    .FlagsIn   (FlagsIn),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutInstr  (OutInstr),
    .OutCondMet(OutCondMet),
    .OutClass  (OutClass),
    .Flags     (Flags),
    .CntClear  (CntClear),
    .CntSel    (CntSel),
    .CntValue  (CntValue)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: pipeline slot, flag register, counters (0..4 classes, 5 skipped)
  bit          m_valid;
  logic [31:0] m_instr;
  bit          m_met;
  logic [4:0]  m_class;
  logic [3:0]  m_flags;
  int          m_cnt [6];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert the even base test.
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int ref_class(input logic [2:0] t);
    if (t == 3'd0) return 0;
    if (t == 3'd1) return 1;
    if (t == 3'd2) return 2;
    if (t == 3'd5) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = '0;
    m_met   = 1'b0;
    m_class = '0;
    m_flags = '0;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
  endtask

  task automatic check_outputs(input bit ordy, input logic [2:0] sel);
    int exp_cnt;
    exp_cnt = (sel < 3'd6) ? m_cnt[sel] : 0;
    check("in_ready",  32'(InReady),    32'(!m_valid || ordy));
    check("out_valid", 32'(OutValid),   32'(m_valid));
    check("out_instr", OutInstr,        m_instr);
    check("cond_met",  32'(OutCondMet), 32'(m_met));
    check("out_class", 32'(OutClass),   32'(m_class));
    check("flags",     32'(Flags),      32'(m_flags));
    check("cnt_value", 32'(CntValue),   exp_cnt);
  endtask

  // One clock: drive at posedge+1, check at posedge+4, advance model, wait for next edge.
  task automatic step(input bit iv, input logic [31:0] ins, input bit ordy,
                      input logic [1:0] fw, input logic [3:0] fin,
                      input bit clr, input logic [2:0] sel);
    logic [3:0] eff;
    bit         acc, met;
    int         cls, k;
    InValid   = iv;
    InInstr   = ins;
    OutReady  = ordy;
    FlagWrite = fw;
    FlagsIn   = fin;
    CntClear  = clr;
    CntSel    = sel;
    #3;
    check_outputs(ordy, sel);
    eff = m_flags;
    if (fw[1]) eff[3:2] = fin[3:2];
    if (fw[0]) eff[1:0] = fin[1:0];
    acc = iv && (!m_valid || ordy);
    met = ref_pass(ins[31:28], eff);
    cls = ref_class(ins[27:25]);
    if (clr) begin
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    end else if (acc) begin
      k = met ? cls : 5;
      if (m_cnt[k] < CNTMAX) m_cnt[k]++;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_instr = ins;
      m_met   = met;
      m_class = met ? 5'(1 << cls) : 5'd0;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    m_flags = eff;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InInstr = '0; OutReady = 1'b1;
    FlagWrite = '0; FlagsIn = '0; CntClear = 1'b0; CntSel = '0;
    model_reset();
    #2;
    check_outputs(1'b1, 3'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Z=1, then EQ R-type passes; next, bypassed Z=0 makes EQ B-type skip
    step(1'b0, 32'h0, 1'b1, 2'b11, 4'b0100, 1'b0, 3'd0);
    step(1'b1, 32'h00800001, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd0);
    step(1'b1, 32'h0A000000, 1'b1, 2'b10, 4'b0000, 1'b0, 3'd0);
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd5);
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd0);

    // Backpressure: first accepted, then held while OutReady stays low
    step(1'b1, 32'hE2000011, 1'b0, 2'b00, 4'b0000, 1'b0, 3'd1);
    step(1'b1, 32'hE2000022, 1'b0, 2'b00, 4'b0000, 1'b0, 3'd1);
    step(1'b1, 32'hE2000033, 1'b0, 2'b00, 4'b0000, 1'b0, 3'd1);
    step(1'b1, 32'hE4000044, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd1);
    step(1'b1, 32'hE4000055, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd2);
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd2);

    // Undef type with AL, then GE/LT with N=1,V=1
    step(1'b0, 32'h0, 1'b1, 2'b11, 4'b1001, 1'b0, 3'd4);
    step(1'b1, 32'hEE000000, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd4);
    step(1'b1, 32'hA0000000, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd4);
    step(1'b1, 32'hB0000000, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd5);
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd5);

    // Saturation of the R counter, then clear racing an accept
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b1, 3'd0);
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'hE0000000, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd0);
    step(1'b1, 32'hE0000000, 1'b1, 2'b00, 4'b0000, 1'b1, 3'd0);
    step(1'b0, 32'h0, 1'b1, 2'b00, 4'b0000, 1'b0, 3'd0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
           2'($urandom), 4'($urandom), 1'($urandom_range(0, 29) == 0),
           3'($urandom_range(0, 7)));

    // Asynchronous reset while an instruction is held
    step(1'b1, 32'hE0000000, 1'b0, 2'b11, 4'b1111, 1'b0, 3'd0);
    step(1'b1, 32'hE2000000, 1'b0, 2'b00, 4'b0000, 1'b0, 3'd0);
    InValid = 1'b0;
    Reset   = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 32'(OutValid),   32'd0);
    check("rst_out_instr", OutInstr,        32'd0);
    check("rst_cond_met",  32'(OutCondMet), 32'd0);
    check("rst_out_class", 32'(OutClass),   32'd0);
    check("rst_flags",     32'(Flags),      32'd0);
    for (int s = 0; s < 6; s++) begin
      CntSel = 3'(s);
      #0.1;
      check("rst_cnt", 32'(CntValue), 32'd0);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(InReady), 32'd1);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           2'($urandom), 4'($urandom), 1'b0, 3'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_type_decode_stage.md
Name: cond_type_decode_stage

Overview:
- Registered, parametrised successor to the combinational type decoder.
- Holds the NZCV flag register and evaluates the full ARM condition field (Instr[31:28]) against it, with same-cycle flag bypass.
- Decodes the type field into a one-hot class vector that is gated by the condition result, and presents it through a one-entry valid/ready pipeline register.
- Keeps saturating per-class execute counters plus a skipped-instruction counter for performance debug.
- Sits between fetch and the control unit.

Parameters:
- INSTR_W, 32, instruction width; the condition field is always the top 4 bits.
- TYPE_LSB, 25, bit position of the type-field LSB.
- TYPE_W, 3, width of the type field.
- CNT_W, 16, width of each statistics counter.

Ports:
- CLK  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  instruction present on InInstr.
- InReady  out  1  stage can accept the instruction this cycle.
- InInstr  in  INSTR_W  instruction word.
- FlagWrite  in  2  [1] updates N,Z; [0] updates C,V (from execute).
- FlagsIn  in  4  new {N,Z,C,V}.
- OutValid  out  1  output register holds a decoded instruction.
- OutReady  in  1  downstream accepts the output.
- OutInstr  out  INSTR_W  registered instruction.
- OutCondMet  out  1  condition passed.
- OutClass  out  5  one-hot {Undef,B,D,I,R}, all zero when the condition fails.
- Flags  out  4  current flag register.
- CntClear  in  1  synchronous clear of all counters.
- CntSel  in  3  counter select: 0=R, 1=I, 2=D, 3=B, 4=Undef, 5=Skipped, others read 0.
- CntValue  out  CNT_W  selected counter, combinational read.

Behaviour:
- Reset (asynchronous, active-high): OutValid=0, OutInstr=0, OutCondMet=0, OutClass=0, Flags=0, all counters 0. Reset mid-transfer drops the held instruction.
- Handshake:
  - InReady = ~OutValid | OutReady.
  - Accept when InValid & InReady. The register loads on accept; OutValid=1 the next cycle (latency 1).
  - If OutValid & OutReady & ~accept, OutValid goes to 0 next cycle.
  - If OutValid & ~OutReady, all outputs hold stable.
  - Back-to-back accepts give full throughput.
- Flags: on each edge, Flags[3:2] <= FlagsIn[3:2] if FlagWrite[1]; Flags[1:0] <= FlagsIn[1:0] if FlagWrite[0]. This happens independently of the handshake.
- Bypass: the condition is evaluated on EffFlags, which is Flags with the FlagWrite-selected fields replaced by FlagsIn in the same cycle.
- Condition table (cond -> pass):
  - 0 EQ Z
  - 1 NE ~Z
  - 2 CS C
  - 3 CC ~C
  - 4 MI N
  - 5 PL ~N
  - 6 VS V
  - 7 VC ~V
  - 8 HI C&~Z
  - 9 LS ~C|Z
  - A GE N==V
  - B LT N!=V
  - C GT ~Z&(N==V)
  - D LE Z|(N!=V)
  - E AL 1
  - F 1 (treated as AL)
- Class decode (type field):
  - 000 -> R
  - 001 -> I
  - 010 -> D
  - 101 -> B
  - any other -> Undef
  - With TYPE_W>3, the upper bits must be 0 for R/I/D/B; otherwise the class is Undef.
  - OutClass = onehot & {5{CondMet}}; exactly one bit is set when the condition passes.
- Counters:
  - Update on accept only: +1 on the class counter if CondMet, else +1 on Skipped.
  - Saturate at all-ones; no wrap.
  - CntClear has priority over an increment in the same cycle; a cleared counter reads 0 next cycle.

Decomposition:
- Shared package: cond code constants (COND_EQ..COND_AL), type encodings (TYPE_R=3'b000, TYPE_I=3'b001, TYPE_D=3'b010, TYPE_B=3'b101), class one-hot bit indices, CntSel encodings.
- One sub-module, cond_check: combinational (cond[3:0], NZCV[3:0]) -> pass. It is reused later by the execute-stage predication.

Test Plan:
- Reset asserted mid-stream with OutValid=1 and counters at 7 -> all outputs and counters read 0 asynchronously; InReady=1 after release.
- Flags=0100 (Z=1), accept EQ R-type 0x00800001 (cond 0, type 000) -> next cycle OutValid=1, OutCondMet=1, OutClass=00001, R counter=1.
- Same cycle: FlagWrite=2'b10, FlagsIn=0000, accept EQ B-type 0x0A000000 -> bypass gives Z=0, so OutCondMet=0, OutClass=0, Skipped=1; Flags=0000 next cycle.
- OutReady=0 for 3 cycles with InValid=1 -> InReady=0 after the first accept; OutInstr stable; only one counter increments; throughput resumes when OutReady=1.
- Type 111, cond E -> OutClass=10000 (Undef). GE with N=1, V=1 -> pass; LT with the same flags -> fail.
- CNT_W=4, 17 R-type accepts -> R counter saturates at 15; CntClear with a simultaneous accept -> reads 0.
